// File: rtl/multicycle_controller.sv
// multicycle_controller: FETCH/DECODE/EXECUTE/WRITEBACK sequencer for an RV32 R-type datapath,
// with a variable-latency fetch handshake, illegal/timeout trapping and a retired-instruction counter.
module multicycle_controller #(
  parameter int COUNT_WIDTH   = 32,
  parameter int FETCH_TIMEOUT = 15
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   run,
  input  logic [31:0]            instruction,
  input  logic                   imem_ready,
  output logic                   imem_req,
  output logic                   ir_load_en,
  output logic                   pc_write_en,
  output logic                   register_write_enable,
  output logic [3:0]             ALU_control,
  output logic                   trap,
  output logic [1:0]             trap_cause,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] instr_count
);
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, TRAP} state_t;
  state_t state, next;
  logic [TW-1:0] wait_cnt;
  logic [31:0] ir;
  logic rtype, legal;
  logic [3:0] alu_dec;
  always_comb begin
    rtype = ir[6:0] == 7'b0110011 &&
            (ir[31:25] == 7'b0000000 ||
             (ir[31:25] == 7'b0100000 && (ir[14:12] == 3'b000 || ir[14:12] == 3'b101)));
    legal = rtype || ir == 32'h0000_0013;
    case ({ir[30], ir[14:12]})
      4'b0001: alu_dec = 4'b0100;
      4'b0010: alu_dec = 4'b1000;
      4'b0011: alu_dec = 4'b1001;
      4'b0100: alu_dec = 4'b0011;
      4'b0101: alu_dec = 4'b0101;
      4'b0110: alu_dec = 4'b0001;
      4'b0111: alu_dec = 4'b0000;
      4'b1000: alu_dec = 4'b0110;
      4'b1101: alu_dec = 4'b0111;
      default: alu_dec = 4'b0010;
    endcase
  end
  always_comb begin
    next = state;
    imem_req = 1'b0;
    pc_write_en = 1'b0;
    busy = 1'b1;
    trap = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        next = run ? FETCH : IDLE;
      end
      FETCH: begin
        imem_req = 1'b1;
        // ready on the limit cycle still wins over the timeout
        next = imem_ready ? DECODE : (wait_cnt == TW'(FETCH_TIMEOUT - 1)) ? TRAP : FETCH;
      end
      DECODE: next = legal ? EXECUTE : TRAP;
      EXECUTE: next = WRITEBACK;
      WRITEBACK: begin
        pc_write_en = 1'b1;
        next = run ? FETCH : IDLE;
      end
      TRAP: begin
        busy = 1'b0;
        trap = 1'b1;
      end
      default: next = IDLE;
    endcase
    ir_load_en = imem_req && imem_ready;
    register_write_enable = pc_write_en && rtype && |ir[11:7];
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state <= IDLE;
      wait_cnt <= '0;
      ir <= '0;
      ALU_control <= 4'b0010;
      trap_cause <= 2'b00;
      instr_count <= '0;
    end else begin
      state <= next;
      wait_cnt <= (state == FETCH && !imem_ready) ? wait_cnt + 1'b1 : '0;
      if (ir_load_en) ir <= instruction;
      if (state == DECODE && legal) ALU_control <= alu_dec;
      if (next == TRAP && state != TRAP) trap_cause <= (state == FETCH) ? 2'b10 : 2'b01;
      if (state == WRITEBACK) instr_count <= instr_count + 1'b1;
    end
  end
endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle sequencer for the RV32 R-type datapath (PC, instruction memory, register file, ALU).
- Replaces the single-cycle combinational controller: steps each instruction through FETCH, DECODE, EXECUTE and WRITEBACK.
- Handshakes with a variable-latency instruction memory and gates PC, instruction-register and register-file write enables.
- Traps on illegal encodings or fetch timeout and counts retired instructions.

Parameters:
- COUNT_WIDTH, 32, width of the retired-instruction counter.
- FETCH_TIMEOUT, 15, maximum cycles spent in FETCH waiting for imem_ready before trapping (must be >= 1).

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset.
- run  input  1  level enable; start fetching from IDLE, stop after current instruction when low.
- instruction  input  32  instruction word from instruction memory (valid when imem_ready=1).
- imem_ready  input  1  instruction memory data valid.
- imem_req  output  1  fetch request to instruction memory.
- ir_load_en  output  1  load instruction register this cycle.
- pc_write_en  output  1  advance PC this cycle.
- register_write_enable  output  1  register file write strobe.
- ALU_control  output  4  ALU operation code.
- trap  output  1  sticky trap flag.
- trap_cause  output  2  00 none, 01 illegal instruction, 10 fetch timeout.
- busy  output  1  high in every state except IDLE and TRAP.
- instr_count  output  COUNT_WIDTH  retired-instruction count.

Behaviour:
- Reset: sampled only on a rising clock edge with reset=0. Reset forces:
  - state=IDLE, ALU_control=4'b0010, trap=0, trap_cause=00, instr_count=0, timeout counter=0.
  - All strobes (imem_req, ir_load_en, pc_write_en, register_write_enable) = 0, busy=0.
  - Reset mid-instruction aborts with no register write and no PC advance.
- State outputs are Moore, decoded from the state register. ALU_control is a register loaded in DECODE.
- IDLE: all strobes 0. Go to FETCH when run=1.
- FETCH:
  - imem_req=1. The timeout counter increments each cycle imem_ready=0.
  - imem_ready=1: ir_load_en=1 combinationally that cycle, counter clears, go to DECODE.
  - Counter reaches FETCH_TIMEOUT with imem_ready still 0: go to TRAP with cause 10. imem_ready in the same cycle as the limit wins.
- DECODE: evaluate the latched instruction.
  - opcode 0110011, funct7 0000000: funct3 000 ADD=0010, 001 SLL=0100, 010 SLT=1000, 011 SLTU=1001, 100 XOR=0011, 101 SRL=0101, 110 OR=0001, 111 AND=0000.
  - opcode 0110011, funct7 0100000: funct3 000 SUB=0110, 101 SRA=0111.
  - Exactly 32'h00000013 (canonical NOP) is legal: ALU_control=0010, write suppressed.
  - Any other encoding: go to TRAP with cause 01. ALU_control holds its previous value.
- EXECUTE: one cycle, ALU_control stable, no strobes.
- WRITEBACK:
  - pc_write_en=1.
  - register_write_enable=1 only when the instruction is R-type and rd (bits 11:7) != 0. rd=x0 and NOP never write.
  - instr_count increments, wrapping from all-ones to 0.
  - Next state: FETCH if run=1, else IDLE.
- run deassertion mid-instruction does not abort; the instruction completes through WRITEBACK.
- Latency: 4 cycles per instruction with zero-wait memory (FETCH, DECODE, EXECUTE, WRITEBACK). Each imem wait cycle adds one.
- TRAP:
  - Terminal until reset. All strobes 0, busy=0, trap=1, trap_cause held.
  - The trapping instruction does not advance the PC or increment instr_count.

Test Plan:
- Reset low 2 cycles, then high, run=1, imem_ready=1, instruction=0x002081B3 (add x3,x1,x2) -> FETCH/DECODE/EXECUTE/WRITEBACK in 4 cycles; ALU_control=0010; register_write_enable and pc_write_en pulse once in cycle 4; instr_count=1.
- Stream of sub (0x40208133), sra (0x4020D133), sltu (0x0020B133), then NOP 0x00000013 -> ALU_control 0110, 0111, 1001, 0010 in turn; NOP gives no write strobe but pc_write_en=1; instr_count=4.
- add x0,x1,x2 (0x00208033) -> register_write_enable stays 0 in WRITEBACK; pc_write_en=1.
- imem_ready held low with FETCH_TIMEOUT=15 -> TRAP after 15 FETCH cycles; trap=1, cause 10, busy=0. A second run: ready asserted on cycle 15 -> DECODE, no trap.
- instruction=0x00208037 (LUI) -> TRAP cause 01; no pc_write_en; instr_count unchanged. reset=0 for one edge -> IDLE, trap cleared.
- run dropped during EXECUTE -> WRITEBACK completes, then IDLE. Reset asserted during EXECUTE -> IDLE next edge with no write strobe. instr_count preset near all-ones (COUNT_WIDTH=4, 15 retirements, then one more) -> wraps to 0.
